pipeline_hazard_ctrl: RTL and testbench

- Central sequencing unit for the 4-stage buffer chain: fetch/decode, decode/execute, execute/memory and memory/writeback buffers.
- Generates the per-buffer load (advance) and flush (synchronous clear through the buffer's reset port) strobes.
- Generates operand-forwarding selects for the execute stage.
- Handles load-use stalls, taken-branch flushes and multi-cycle memory waits; a timeout watchdog halts the pipeline on a hung memory.

---
 rtl/pipe_pkg.sv | 58 +++++
 rtl/pipeline_hazard_ctrl_if.sv | 55 +++++
 rtl/pipeline_hazard_ctrl_fwd.sv | 31 +++
 rtl/pipeline_hazard_ctrl.sv | 113 +++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared types for the pipeline hazard controller: FSM states, forwarding
// selects and the bundle of buffer strobes the controller drives.
package pipe_pkg;

    localparam int REG_AW_DEFAULT = 4;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } ctrl_state_t;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef struct packed {
        logic pc_load;
        logic fd_load;
        logic de_load;
        logic em_load;
        logic mw_load;
        logic fd_flush;
        logic de_flush;
        logic em_flush;
    } strobe_t;

    localparam strobe_t STROBE_FREEZE = '0;
    localparam strobe_t STROBE_RESET  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    // Strobes for a cycle in which the pipeline is free to move: a taken branch
    // squashes the decode instruction, so it outranks a load-use bubble.
    function automatic strobe_t run_strobes(input logic pc_src, input logic load_use);
        strobe_t s;
        s = '0;
        if (pc_src) begin
            s.pc_load  = 1'b1;
            s.fd_flush = 1'b1;
            s.de_flush = 1'b1;
            s.em_load  = 1'b1;
            s.mw_load  = 1'b1;
        end else if (load_use) begin
            s.de_flush = 1'b1;
            s.em_load  = 1'b1;
            s.mw_load  = 1'b1;
        end else begin
            s.pc_load = 1'b1;
            s.fd_load = 1'b1;
            s.de_load = 1'b1;
            s.em_load = 1'b1;
            s.mw_load = 1'b1;
        end
        return s;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle between the pipeline datapath and its hazard controller.
// master = controller side, slave = datapath side.
interface pipeline_hazard_ctrl_if
    import pipe_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEFAULT,
    parameter int CNT_W  = 16
);
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_use1;
    logic              id_use2;
    logic [REG_AW-1:0] ex_rs1;
    logic [REG_AW-1:0] ex_rs2;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_reg_write;
    logic              ex_mem_to_reg;
    logic              ex_pc_src;
    logic [REG_AW-1:0] mem_rd;
    logic              mem_reg_write;
    logic [REG_AW-1:0] wb_rd;
    logic              wb_reg_write;
    logic              mem_req;
    logic              mem_ready;

    fwd_sel_t          fwd_a;
    fwd_sel_t          fwd_b;
    logic              pc_load;
    logic              fd_load;
    logic              de_load;
    logic              em_load;
    logic              mw_load;
    logic              fd_flush;
    logic              de_flush;
    logic              em_flush;
    logic              halted;
    logic [CNT_W-1:0]  stall_count;

    modport master (
        input  id_rs1, id_rs2, id_use1, id_use2,
        input  ex_rs1, ex_rs2, ex_rd, ex_reg_write, ex_mem_to_reg, ex_pc_src,
        input  mem_rd, mem_reg_write, wb_rd, wb_reg_write, mem_req, mem_ready,
        output fwd_a, fwd_b, pc_load, fd_load, de_load, em_load, mw_load,
        output fd_flush, de_flush, em_flush, halted, stall_count
    );

    modport slave (
        output id_rs1, id_rs2, id_use1, id_use2,
        output ex_rs1, ex_rs2, ex_rd, ex_reg_write, ex_mem_to_reg, ex_pc_src,
        output mem_rd, mem_reg_write, wb_rd, wb_reg_write, mem_req, mem_ready,
        input  fwd_a, fwd_b, pc_load, fd_load, de_load, em_load, mw_load,
        input  fd_flush, de_flush, em_flush, halted, stall_count
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_fwd.sv
// Execute-stage operand forwarding compare; the younger (mem-stage) result
// always wins over the writeback result.
module fwd_unit
    import pipe_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEFAULT
) (
    input  logic [REG_AW-1:0] ex_rs1,
    input  logic [REG_AW-1:0] ex_rs2,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_reg_write,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_reg_write,
    output fwd_sel_t          fwd_a,
    output fwd_sel_t          fwd_b
);

    // Register 0 is not special here: the datapath owns any hardwired-zero rule.
    function automatic fwd_sel_t select_src(input logic [REG_AW-1:0] rs);
        if (mem_reg_write && (mem_rd == rs)) begin
            return FWD_MEM;
        end else if (wb_reg_write && (wb_rd == rs)) begin
            return FWD_WB;
        end
        return FWD_RF;
    endfunction

    assign fwd_a = select_src(ex_rs1);
    assign fwd_b = select_src(ex_rs2);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the 4-buffer pipeline: buffer load/flush strobes,
// load-use bubbles, branch squash, memory-wait freeze and timeout halt.
module pipeline_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int REG_AW      = REG_AW_DEFAULT,
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    pipeline_hazard_ctrl_if.master bus
);

    localparam int                WAIT_W      = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] TIMEOUT_CNT = WAIT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_MAX     = '1;

    ctrl_state_t       state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    fwd_sel_t          fwd_a_raw, fwd_b_raw;
    logic              load_use;
    strobe_t           strobes;

    fwd_unit #(
        .REG_AW (REG_AW)
    ) u_fwd (
        .ex_rs1        (bus.ex_rs1),
        .ex_rs2        (bus.ex_rs2),
        .mem_rd        (bus.mem_rd),
        .mem_reg_write (bus.mem_reg_write),
        .wb_rd         (bus.wb_rd),
        .wb_reg_write  (bus.wb_reg_write),
        .fwd_a         (fwd_a_raw),
        .fwd_b         (fwd_b_raw)
    );

    assign load_use = bus.ex_mem_to_reg && bus.ex_reg_write &&
                      ((bus.id_use1 && (bus.id_rs1 == bus.ex_rd)) ||
                       (bus.id_use2 && (bus.id_rs2 == bus.ex_rd)));

    always_comb begin
        // NOTE: every value written here gets a default first, so no path can infer a latch.
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        stall_cnt_d = stall_cnt_q;
        strobes     = STROBE_FREEZE;

        // NOTE: reset is synchronous, so it is folded into the next-state logic rather than the flop sensitivity.
        if (reset) begin
            state_d     = RUN;
            wait_cnt_d  = '0;
            stall_cnt_d = '0;
            strobes     = STROBE_RESET;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (bus.mem_req && !bus.mem_ready) begin
                        state_d    = MEM_WAIT;
                        wait_cnt_d = WAIT_W'(1);
                    end else begin
                        strobes = run_strobes(bus.ex_pc_src, load_use);
                    end
                end
                MEM_WAIT: begin
                    if (bus.mem_ready) begin
                        strobes    = run_strobes(bus.ex_pc_src, load_use);
                        state_d    = RUN;
                        wait_cnt_d = '0;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                        if (wait_cnt_d == TIMEOUT_CNT) begin
                            state_d = HALT;
                        end
                    end
                end
                HALT: begin
                    state_d = HALT;
                end
                default: begin
                    state_d = RUN;
                end
            endcase

            // A held PC is a lost issue slot; a halted pipe is not counted.
            if ((state_q != HALT) && !strobes.pc_load && (stall_cnt_q != CNT_MAX)) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        state_q     <= state_d;
        wait_cnt_q  <= wait_cnt_d;
        stall_cnt_q <= stall_cnt_d;
    end

    assign bus.fwd_a       = reset ? FWD_RF : fwd_a_raw;
    assign bus.fwd_b       = reset ? FWD_RF : fwd_b_raw;
    assign bus.pc_load     = strobes.pc_load;
    assign bus.fd_load     = strobes.fd_load;
    assign bus.de_load     = strobes.de_load;
    assign bus.em_load     = strobes.em_load;
    assign bus.mw_load     = strobes.mw_load;
    assign bus.fd_flush    = strobes.fd_flush;
    assign bus.de_flush    = strobes.de_flush;
    assign bus.em_flush    = strobes.em_flush;
    assign bus.halted      = (state_q == HALT);
    assign bus.stall_count = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed vectors with literal
// expectations plus a per-cycle behavioural model of the hazard rules.
module tb_pipeline_hazard_ctrl;
    import pipe_pkg::*;

    localparam int REG_AW      = 4;
    localparam int CNT_W       = 16;
    localparam int MEM_TIMEOUT = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) bus_if ();

    pipeline_hazard_ctrl #(
        .REG_AW      (REG_AW),
        .CNT_W       (CNT_W),
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.master)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // Strobe vector order: {pc, fd, de, em, mw load, fd, de, em flush}.
    bit         m_on = 1'b0;
    bit         m_halted, m_waiting, m_frozen_now, m_load_use;
    int         m_frozen_cycles, m_stalls;
    logic [7:0] m_exp, m_act;

    function automatic logic [1:0] exp_fwd(input logic [REG_AW-1:0] rs);
        if (bus_if.mem_reg_write && bus_if.mem_rd == rs) return 2'b10;
        if (bus_if.wb_reg_write && bus_if.wb_rd == rs) return 2'b01;
        return 2'b00;
    endfunction

    always @(negedge clk) begin
        if (m_on) begin
            m_load_use = bus_if.ex_mem_to_reg && bus_if.ex_reg_write &&
                         ((bus_if.id_use1 && bus_if.id_rs1 == bus_if.ex_rd) ||
                          (bus_if.id_use2 && bus_if.id_rs2 == bus_if.ex_rd));
            m_frozen_now = m_waiting ? !bus_if.mem_ready : (bus_if.mem_req && !bus_if.mem_ready);

            if (reset)                 m_exp = 8'b00000_111;
            else if (m_halted)         m_exp = 8'b00000_000;
            else if (m_frozen_now)     m_exp = 8'b00000_000;
            else if (bus_if.ex_pc_src) m_exp = 8'b10011_110;
            else if (m_load_use)       m_exp = 8'b00011_010;
            else                       m_exp = 8'b11111_000;

            m_act = {bus_if.pc_load, bus_if.fd_load, bus_if.de_load, bus_if.em_load,
                     bus_if.mw_load, bus_if.fd_flush, bus_if.de_flush, bus_if.em_flush};
            check("model_strobes", m_act, m_exp);
            check("model_fwd_a", bus_if.fwd_a, reset ? 2'b00 : exp_fwd(bus_if.ex_rs1));
            check("model_fwd_b", bus_if.fwd_b, reset ? 2'b00 : exp_fwd(bus_if.ex_rs2));
            check("model_halted", bus_if.halted, m_halted);
            check("model_stall_count", bus_if.stall_count, m_stalls);

            if (reset) begin
                m_halted = 0; m_waiting = 0; m_frozen_cycles = 0; m_stalls = 0;
            end else if (!m_halted) begin
                if (!m_exp[7] && m_stalls < (1 << CNT_W) - 1) m_stalls++;
                if (m_frozen_now) begin
                    m_frozen_cycles++;
                    m_waiting = 1;
                    if (m_frozen_cycles >= MEM_TIMEOUT) begin
                        m_halted = 1; m_waiting = 0;
                    end
                end else begin
                    m_waiting = 0; m_frozen_cycles = 0;
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic clear_inputs();
        bus_if.id_rs1 = '0;        bus_if.id_rs2 = '0;
        bus_if.id_use1 = 1'b0;     bus_if.id_use2 = 1'b0;
        bus_if.ex_rs1 = '0;        bus_if.ex_rs2 = '0;       bus_if.ex_rd = '0;
        bus_if.ex_reg_write = 1'b0; bus_if.ex_mem_to_reg = 1'b0; bus_if.ex_pc_src = 1'b0;
        bus_if.mem_rd = '0;        bus_if.mem_reg_write = 1'b0;
        bus_if.wb_rd = '0;         bus_if.wb_reg_write = 1'b0;
        bus_if.mem_req = 1'b0;     bus_if.mem_ready = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic set_load_use();
        bus_if.ex_mem_to_reg = 1'b1; bus_if.ex_reg_write = 1'b1; bus_if.ex_rd = 4'd4;
        bus_if.id_use2 = 1'b1;       bus_if.id_rs2 = 4'd4;
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        next_cycle();
        m_on = 1'b1;

        // Reset: forwarding candidates present but selects must read 00.
        bus_if.mem_reg_write = 1'b1;
        sample();
        check("rst_pc_load", bus_if.pc_load, 1'b0);
        check("rst_fd_load", bus_if.fd_load, 1'b0);
        check("rst_fd_flush", bus_if.fd_flush, 1'b1);
        check("rst_de_flush", bus_if.de_flush, 1'b1);
        check("rst_em_flush", bus_if.em_flush, 1'b1);
        check("rst_fwd_a", bus_if.fwd_a, 2'b00);
        check("rst_stall_count", bus_if.stall_count, 0);

        next_cycle();
        reset = 1'b0;
        clear_inputs();
        sample();
        check("run_pc_load", bus_if.pc_load, 1'b1);
        check("run_de_load", bus_if.de_load, 1'b1);
        check("run_mw_load", bus_if.mw_load, 1'b1);
        check("run_fd_flush", bus_if.fd_flush, 1'b0);

        // Forwarding priority.
        next_cycle();
        bus_if.mem_reg_write = 1'b1; bus_if.mem_rd = 4'd3;
        bus_if.wb_reg_write = 1'b1;  bus_if.wb_rd = 4'd3;
        bus_if.ex_rs1 = 4'd3;        bus_if.ex_rs2 = 4'd5;
        sample();
        check("fwd_mem_a", bus_if.fwd_a, 2'b10);
        check("fwd_mem_b", bus_if.fwd_b, 2'b00);
        next_cycle();
        bus_if.mem_reg_write = 1'b0;
        sample();
        check("fwd_wb_a", bus_if.fwd_a, 2'b01);
        next_cycle();
        clear_inputs();
        bus_if.wb_reg_write = 1'b1;
        sample();
        check("fwd_r0_a", bus_if.fwd_a, 2'b01);
        check("fwd_r0_b", bus_if.fwd_b, 2'b01);

        // Load-use bubble.
        next_cycle();
        clear_inputs();
        set_load_use();
        sample();
        check("lu_pc_load", bus_if.pc_load, 1'b0);
        check("lu_fd_load", bus_if.fd_load, 1'b0);
        check("lu_de_flush", bus_if.de_flush, 1'b1);
        check("lu_em_load", bus_if.em_load, 1'b1);
        next_cycle();
        clear_inputs();
        sample();
        check("lu_after_pc_load", bus_if.pc_load, 1'b1);
        check("lu_after_fd_load", bus_if.fd_load, 1'b1);
        check("lu_after_stall", bus_if.stall_count, 1);

        // Branch overrides load-use.
        next_cycle();
        set_load_use();
        bus_if.ex_pc_src = 1'b1;
        sample();
        check("br_pc_load", bus_if.pc_load, 1'b1);
        check("br_fd_flush", bus_if.fd_flush, 1'b1);
        check("br_de_flush", bus_if.de_flush, 1'b1);
        check("br_fd_load", bus_if.fd_load, 1'b0);
        next_cycle();
        clear_inputs();
        sample();
        check("br_after_stall", bus_if.stall_count, 1);

        // Memory wait: five frozen cycles, resume on ready.
        next_cycle();
        bus_if.mem_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sample();
            check("mw_freeze_pc_load", bus_if.pc_load, 1'b0);
            next_cycle();
        end
        bus_if.mem_ready = 1'b1;
        sample();
        check("mw_ready_pc_load", bus_if.pc_load, 1'b1);
        check("mw_ready_de_load", bus_if.de_load, 1'b1);
        next_cycle();
        clear_inputs();
        sample();
        check("mw_stall", bus_if.stall_count, 6);

        // Memory wait that resolves together with a taken branch.
        next_cycle();
        bus_if.mem_req = 1'b1;
        for (int i = 0; i < 2; i++) begin
            sample();
            next_cycle();
        end
        bus_if.mem_ready = 1'b1;
        bus_if.ex_pc_src = 1'b1;
        sample();
        check("mwbr_fd_flush", bus_if.fd_flush, 1'b1);
        check("mwbr_pc_load", bus_if.pc_load, 1'b1);
        check("mwbr_stall", bus_if.stall_count, 8);

        // Timeout into HALT.
        next_cycle();
        clear_inputs();
        bus_if.mem_req = 1'b1;
        for (int i = 0; i < MEM_TIMEOUT; i++) begin
            sample();
            check("to_not_halted", bus_if.halted, 1'b0);
            next_cycle();
        end
        sample();
        check("to_halted", bus_if.halted, 1'b1);
        check("to_pc_load", bus_if.pc_load, 1'b0);
        check("to_stall", bus_if.stall_count, 16);
        next_cycle();
        bus_if.mem_ready = 1'b1;
        bus_if.ex_pc_src = 1'b1;
        sample();
        check("halt_sticky", bus_if.halted, 1'b1);
        check("halt_mw_load", bus_if.mw_load, 1'b0);
        check("halt_stall", bus_if.stall_count, 16);

        // Reset out of HALT.
        next_cycle();
        reset = 1'b1;
        clear_inputs();
        sample();
        check("halt_rst_em_flush", bus_if.em_flush, 1'b1);
        next_cycle();
        reset = 1'b0;
        sample();
        check("post_halt_halted", bus_if.halted, 1'b0);
        check("post_halt_pc_load", bus_if.pc_load, 1'b1);
        check("post_halt_stall", bus_if.stall_count, 0);

        // Reset in the middle of a memory wait.
        next_cycle();
        bus_if.mem_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sample();
            next_cycle();
        end
        reset = 1'b1;
        sample();
        check("mid_rst_de_flush", bus_if.de_flush, 1'b1);
        next_cycle();
        reset = 1'b0;
        clear_inputs();
        sample();
        check("mid_rst_pc_load", bus_if.pc_load, 1'b1);
        check("mid_rst_stall", bus_if.stall_count, 0);

        next_cycle();
        sample();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
